// File: rtl/if_id_buffer_pkg.sv
// Shared ISA definitions: NOP encoding and opcode field placement used by the fetch/decode boundary.
package if_id_buffer_pkg;

  localparam int          ISA_WIDTH     = 16;
  localparam logic [15:0] ISA_NOP_INSTR = 16'h0800;
  localparam int          ISA_OPC_HI    = 15;
  localparam int          ISA_OPC_LO    = 11;
  localparam logic [4:0]  ISA_OPC_HALT  = 5'b00000;

  function automatic logic is_halt(input logic [ISA_WIDTH-1:0] instr);
    return instr[ISA_OPC_HI:ISA_OPC_LO] == ISA_OPC_HALT;
  endfunction

endpackage

// File: rtl/if_id_buffer_if.sv
// Fetch-side push and decode-side pop signals of the IF/ID buffer.
interface if_id_buffer_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] instr;
  logic [WIDTH-1:0] PC;
  logic [WIDTH-1:0] PCPlus1;
  logic             if_valid;
  logic             if_ready;
  logic             flush;
  logic             id_ready;
  logic             id_valid;
  logic [WIDTH-1:0] id_instr;
  logic [WIDTH-1:0] id_PC;
  logic [WIDTH-1:0] id_PCPlus1;
  logic [1:0]       count;
  logic             halted;

  modport slave (
    input  instr, PC, PCPlus1, if_valid, flush, id_ready,
    output if_ready, id_valid, id_instr, id_PC, id_PCPlus1, count, halted
  );

  modport master (
    output instr, PC, PCPlus1, if_valid, flush, id_ready,
    input  if_ready, id_valid, id_instr, id_PC, id_PCPlus1, count, halted
  );
endinterface

// File: rtl/if_id_entry.sv
// One buffer slot: W-bit register with load enable, async reset to RST_VAL.
module if_id_entry #(
  parameter int           W       = 48,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         data_q <= RST_VAL;
    else if (load_i) data_q <= d_i;
  end

  assign q_o = data_q;

endmodule

// File: rtl/if_id_buffer.sv
// 2-entry IF/ID skid FIFO; 1-cycle push-to-valid latency, if_ready from state only.
// Flush beats push/pop; an accepted HALT freezes fetch until flush or reset.
module if_id_buffer
  import if_id_buffer_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] NOP_INSTR = ISA_NOP_INSTR
) (
  input  logic                 clk,
  input  logic                 rst,
  if_id_buffer_if.slave        bus
);

  localparam int EW = 3 * WIDTH;

  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [1:0]    count_q, count_d;
  logic          halted_q, halted_d;
  logic          if_ready;
  logic          push, pop;
  logic [1:0]    load_en;
  logic [EW-1:0] wdat;
  logic [EW-1:0] head;
  logic [EW-1:0] ent_q [2];

  assign if_ready = (count_q < 2'd2) && !halted_q;
  assign push     = bus.if_valid && if_ready && !bus.flush;
  assign pop      = (count_q != 2'd0) && bus.id_ready && !bus.flush;
  assign wdat     = {bus.instr, bus.PC, bus.PCPlus1};

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    halted_d = halted_q;
    load_en  = '0;
    if (bus.flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
      halted_d = 1'b0;
    end else begin
      if (push) begin
        load_en[wr_ptr_q] = 1'b1;
        wr_ptr_d          = ~wr_ptr_q;
        if (bus.instr[ISA_OPC_HI:ISA_OPC_LO] == ISA_OPC_HALT) halted_d = 1'b1;
      end
      if (pop) rd_ptr_d = ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      halted_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      halted_q <= halted_d;
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_ent
    if_id_entry #(
      .W       (EW),
      .RST_VAL ({NOP_INSTR, {(2*WIDTH){1'b0}}})
    ) u_entry (
      .clk    (clk),
      .rst    (rst),
      .load_i (load_en[i]),
      .d_i    (wdat),
      .q_o    (ent_q[i])
    );
  end

  // Empty buffer presents a bubble regardless of stale slot contents.
  assign head           = ent_q[rd_ptr_q];
  assign bus.if_ready   = if_ready;
  assign bus.id_valid   = (count_q != 2'd0);
  assign bus.id_instr   = (count_q == 2'd0) ? NOP_INSTR : head[EW-1 -: WIDTH];
  assign bus.id_PC      = (count_q == 2'd0) ? '0 : head[2*WIDTH-1 -: WIDTH];
  assign bus.id_PCPlus1 = (count_q == 2'd0) ? '0 : head[WIDTH-1:0];
  assign bus.count      = count_q;
  assign bus.halted     = halted_q;

endmodule
